// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 two-port memory model: per-port state
// encoding, the stall LFSR tap mask and its step function.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } port_state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Wait counter width: holds up to 15 base waits plus 3 random waits
    localparam int CNT_W = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lc3_mem_port.sv
// One memory port: captures a request, counts down its wait states and
// signals the completing edge. A dropped request during WAIT aborts quietly.
module lc3_mem_port #(
    parameter int IDX_W  = 10,
    parameter int DATA_W = 16,
    parameter int LAT    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    input  logic [IDX_W-1:0]  idx,
    input  logic [1:0]        extra,
    output logic              fire,
    output logic [IDX_W-1:0]  cap_idx,
    output logic              cap_rd,
    output logic [DATA_W-1:0] cap_din,
    output logic              complete
);
    import lc3_mem_pkg::*;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

    port_state_e      state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_load_s;
    logic             load_s;
    logic             fire_s;
    logic             complete_r;
    logic [IDX_W-1:0] cap_idx_r;
    logic             cap_rd_r;
    logic [DATA_W-1:0] cap_din_r;

    assign cnt_load_s = LAT_C + {{(CNT_W-2){1'b0}}, extra};

    // Next-state, counter and capture/fire decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        fire_s      = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                // DONE also accepts a held request so accesses run back to back
                if (req) begin
                    load_s      = 1'b1;
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = cnt_load_s;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = DONE;
                    fire_s      = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and completion pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            complete_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            complete_r <= fire_s;
        end
    end

    // Request capture taken when an access starts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_idx_r <= {IDX_W{1'b0}};
            cap_rd_r  <= 1'b0;
            cap_din_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            cap_idx_r <= idx;
            cap_rd_r  <= rd;
            cap_din_r <= din;
        end
    end

    assign fire     = fire_s;
    assign cap_idx  = cap_idx_r;
    assign cap_rd   = cap_rd_r;
    assign cap_din  = cap_din_r;
    assign complete = complete_r;

endmodule

// File: rtl/lc3_mem_model.sv
// LC-3 instruction/data memory model: one shared array, independent
// instruction and data ports with configurable and optional random waits.
module lc3_mem_model #(
    parameter int          DATA_W     = 16,
    parameter int          ADDR_W     = 16,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          I_LAT      = 0,
    parameter int          D_LAT      = 0,
    parameter int          RAND_STALL = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instrmem_rd,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic              Data_rd,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data
);
    import lc3_mem_pkg::*;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem_r [0:DEPTH-1];
    logic [15:0]           lfsr_r;
    logic [1:0]            i_extra_s, d_extra_s;
    logic                  i_fire_s, d_fire_s;
    logic [DEPTH_LOG2-1:0] i_idx_s, d_idx_s;
    logic                  d_rd_s;
    logic [DATA_W-1:0]     d_din_s;
    logic [DATA_W-1:0]     instr_dout_r, data_dout_r;
    logic                  i_rd_unused_s;
    logic [DATA_W-1:0]     i_din_unused_s;
    logic                  unused_addr_s;

    // Address bits above the array index wrap silently
    assign unused_addr_s = ^{pc[ADDR_W-1:DEPTH_LOG2], Data_addr[ADDR_W-1:DEPTH_LOG2]};

    // Extra random waits per port, taken from disjoint LFSR bits
    always_comb begin
        if (RAND_STALL != 0) begin
            i_extra_s = lfsr_r[1:0];
            d_extra_s = lfsr_r[3:2];
        end else begin
            i_extra_s = 2'b00;
            d_extra_s = 2'b00;
        end
    end

    lc3_mem_port #(.IDX_W(DEPTH_LOG2), .DATA_W(DATA_W), .LAT(I_LAT)) u_iport (
        .clock    (clock),
        .reset    (reset),
        .req      (instrmem_rd),
        .rd       (1'b1),
        .din      ({DATA_W{1'b0}}),
        .idx      (pc[DEPTH_LOG2-1:0]),
        .extra    (i_extra_s),
        .fire     (i_fire_s),
        .cap_idx  (i_idx_s),
        .cap_rd   (i_rd_unused_s),
        .cap_din  (i_din_unused_s),
        .complete (complete_instr)
    );

    lc3_mem_port #(.IDX_W(DEPTH_LOG2), .DATA_W(DATA_W), .LAT(D_LAT)) u_dport (
        .clock    (clock),
        .reset    (reset),
        .req      (data_req),
        .rd       (Data_rd),
        .din      (Data_din),
        .idx      (Data_addr[DEPTH_LOG2-1:0]),
        .extra    (d_extra_s),
        .fire     (d_fire_s),
        .cap_idx  (d_idx_s),
        .cap_rd   (d_rd_s),
        .cap_din  (d_din_s),
        .complete (complete_data)
    );

    // Stall LFSR, one step per cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Array write on the completing edge of a data write; contents survive reset
    always_ff @(posedge clock) begin
        if (d_fire_s && !d_rd_s) begin
            mem_r[d_idx_s] <= d_din_s;
        end
    end

    // Read data registers; same-edge reads see the pre-write word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_dout_r <= {DATA_W{1'b0}};
            data_dout_r  <= {DATA_W{1'b0}};
        end else begin
            if (i_fire_s) begin
                instr_dout_r <= mem_r[i_idx_s];
            end
            if (d_fire_s && d_rd_s) begin
                data_dout_r <= mem_r[d_idx_s];
            end
        end
    end

    assign Instr_dout = instr_dout_r;
    assign Data_dout  = data_dout_r;

endmodule

// File: tb/tb_lc3_mem_model.sv
// Directed bench for lc3_mem_model. Instance 0: I_LAT=0, D_LAT=3, no random
// stall. Instance 1: I_LAT=2, D_LAT=2, random stall on.
module tb_lc3_mem_model;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pc_v    [2];
    logic        ird_v   [2];
    logic [15:0] idout_v [2];
    logic        ci_v    [2];
    logic        dreq_v  [2];
    logic [15:0] daddr_v [2];
    logic        drd_v   [2];
    logic [15:0] ddin_v  [2];
    logic [15:0] ddout_v [2];
    logic        cd_v    [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    lc3_mem_model #(.I_LAT(0), .D_LAT(3), .RAND_STALL(0)) u_dut0 (
        .clock(clock), .reset(reset_n),
        .pc(pc_v[0]), .instrmem_rd(ird_v[0]), .Instr_dout(idout_v[0]), .complete_instr(ci_v[0]),
        .data_req(dreq_v[0]), .Data_addr(daddr_v[0]), .Data_rd(drd_v[0]), .Data_din(ddin_v[0]),
        .Data_dout(ddout_v[0]), .complete_data(cd_v[0])
    );

    lc3_mem_model #(.I_LAT(2), .D_LAT(2), .RAND_STALL(1)) u_dut1 (
        .clock(clock), .reset(reset_n),
        .pc(pc_v[1]), .instrmem_rd(ird_v[1]), .Instr_dout(idout_v[1]), .complete_instr(ci_v[1]),
        .data_req(dreq_v[1]), .Data_addr(daddr_v[1]), .Data_rd(drd_v[1]), .Data_din(ddin_v[1]),
        .Data_dout(ddout_v[1]), .complete_data(cd_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Data access; n = posedges from the sampling edge up to the one after which complete is seen
    task automatic d_access(input int s, input logic [15:0] addr, input logic rd,
                            input logic [15:0] din, output int n);
        @(negedge clock);
        daddr_v[s] = addr; drd_v[s] = rd; ddin_v[s] = din; dreq_v[s] = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!cd_v[s] && n < 40);
        dreq_v[s] = 1'b0;
    endtask

    task automatic i_access(input int s, input logic [15:0] addr, output int n);
        @(negedge clock);
        pc_v[s] = addr; ird_v[s] = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!ci_v[s] && n < 40);
        ird_v[s] = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] model [16];
        for (int k = 0; k < 2; k++) begin
            pc_v[k] = 16'h0000; ird_v[k] = 1'b0; dreq_v[k] = 1'b0;
            daddr_v[k] = 16'h0000; drd_v[k] = 1'b0; ddin_v[k] = 16'h0000;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("rst_instr_dout", idout_v[0], 16'h0000);
        chk("rst_data_dout", ddout_v[0], 16'h0000);
        chk("rst_complete_i", ci_v[0], 1'b0);
        chk("rst_complete_d", cd_v[0], 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // ---------------- instance 0: fixed latencies ----------------
        d_access(0, 16'h3000, 1'b0, 16'h1234, n);
        chk("wr3000_lat", n, 5);
        chk("wr_keeps_dout", ddout_v[0], 16'h0000);
        i_access(0, 16'h3000, n);
        chk("if3000_lat", n, 2);
        chk("if3000_data", idout_v[0], 16'h1234);

        d_access(0, 16'h0040, 1'b0, 16'hBEEF, n);
        chk("wr0040_lat", n, 5);
        d_access(0, 16'h0040, 1'b1, 16'h0000, n);
        chk("rd0040_lat", n, 5);
        chk("rd0040_data", ddout_v[0], 16'hBEEF);
        repeat (4) @(posedge clock);
        #1;
        chk("dout_hold", ddout_v[0], 16'hBEEF);
        chk("idout_hold", idout_v[0], 16'h1234);

        // back-to-back fetches with the request held high
        @(negedge clock);
        pc_v[0] = 16'h3000; ird_v[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("b2b_first_done", ci_v[0], 1'b1);
        chk("b2b_first_data", idout_v[0], 16'h1234);
        pc_v[0] = 16'h0040;
        @(posedge clock); #1;
        chk("b2b_gap", ci_v[0], 1'b0);
        @(posedge clock); #1;
        chk("b2b_second_done", ci_v[0], 1'b1);
        chk("b2b_second_data", idout_v[0], 16'hBEEF);
        ird_v[0] = 1'b0;
        @(posedge clock); #1;
        chk("b2b_pulse_one", ci_v[0], 1'b0);

        // same-edge data write and fetch on index 5: fetch sees the old word
        d_access(0, 16'h0005, 1'b0, 16'h0005, n);
        @(negedge clock);
        daddr_v[0] = 16'h0005; ddin_v[0] = 16'hAAAA; drd_v[0] = 1'b0; dreq_v[0] = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        pc_v[0] = 16'h0005; ird_v[0] = 1'b1;
        @(posedge clock);
        @(posedge clock); #1;
        chk("rbw_cd", cd_v[0], 1'b1);
        chk("rbw_ci", ci_v[0], 1'b1);
        chk("rbw_old", idout_v[0], 16'h0005);
        dreq_v[0] = 1'b0; ird_v[0] = 1'b0;
        i_access(0, 16'h0005, n);
        chk("rbw_new", idout_v[0], 16'hAAAA);

        // index wrap
        d_access(0, 16'h0401, 1'b0, 16'h7777, n);
        d_access(0, 16'h0001, 1'b1, 16'h0000, n);
        chk("wrap_data", ddout_v[0], 16'h7777);
        i_access(0, 16'hFC01, n);
        chk("wrap_instr", idout_v[0], 16'h7777);

        // ---------------- instance 1: random stalls ----------------
        d_access(1, 16'h0020, 1'b0, 16'h1111, n);
        chk("r_wr_lat", (n >= 4 && n <= 7), 1'b1);
        i_access(1, 16'h0020, n);
        chk("r_if_data", idout_v[1], 16'h1111);

        // aborted write
        @(negedge clock);
        daddr_v[1] = 16'h0020; ddin_v[1] = 16'h5555; drd_v[1] = 1'b0; dreq_v[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        dreq_v[1] = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (cd_v[1]) seen++;
        end
        chk("abort_no_pulse", seen, 0);
        d_access(1, 16'h0020, 1'b1, 16'h0000, n);
        chk("abort_no_write", ddout_v[1], 16'h1111);

        // asynchronous reset in the middle of WAIT on both ports
        @(negedge clock);
        daddr_v[1] = 16'h0020; drd_v[1] = 1'b1; dreq_v[1] = 1'b1;
        pc_v[1] = 16'h0020; ird_v[1] = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_instr_dout", idout_v[1], 16'h0000);
        chk("arst_data_dout", ddout_v[1], 16'h0000);
        chk("arst_ci", ci_v[1], 1'b0);
        chk("arst_cd", cd_v[1], 1'b0);
        dreq_v[1] = 1'b0; ird_v[1] = 1'b0;
        seen = 0;
        repeat (2) begin
            @(posedge clock); #1;
            if (cd_v[1] || ci_v[1]) seen++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (8) begin
            @(posedge clock); #1;
            if (cd_v[1] || ci_v[1]) seen++;
        end
        chk("arst_no_pulse", seen, 0);
        d_access(1, 16'h0020, 1'b1, 16'h0000, n);
        chk("arst_array_kept", ddout_v[1], 16'h1111);

        // fill 16 words, then random accesses with latency and data checks
        for (int k = 0; k < 16; k++) begin
            model[k] = 16'(k * 16'h0101 + 16'h0F00);
            d_access(1, 16'(k), 1'b0, model[k], n);
            chk("fill_lat", (n >= 4 && n <= 7), 1'b1);
        end
        for (int t = 0; t < 1000; t++) begin
            logic [3:0]  idx;
            logic [15:0] addr;
            logic [15:0] wd;
            idx  = 4'($urandom_range(0, 15));
            addr = {6'($urandom_range(0, 63)), 6'b000000, idx};
            if ($urandom_range(0, 1) == 0) begin
                i_access(1, addr, n);
                chk("rnd_if_lat", (n >= 4 && n <= 7), 1'b1);
                chk("rnd_if_data", idout_v[1], model[idx]);
            end else if ($urandom_range(0, 1) == 0) begin
                d_access(1, addr, 1'b1, 16'h0000, n);
                chk("rnd_rd_lat", (n >= 4 && n <= 7), 1'b1);
                chk("rnd_rd_data", ddout_v[1], model[idx]);
            end else begin
                wd = 16'($urandom_range(0, 65535));
                d_access(1, addr, 1'b0, wd, n);
                chk("rnd_wr_lat", (n >= 4 && n <= 7), 1'b1);
                model[idx] = wd;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_model.md
LC3_MEM_MODEL -- requirements
Module: lc3_mem_model

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning instruction/data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the shared array depth.
REQ-004 The block SHALL have parameters I_LAT and D_LAT, default 0 each (range 0-15), meaning base wait states per port.
REQ-005 The block SHALL have parameter RAND_STALL, default 0, meaning 1 adds 0-3 pseudo-random extra waits per access.
REQ-006 The block SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero stall LFSR seed.
REQ-007 The block SHALL have port clock, input, 1 bit: single clock; all logic is rising-edge.
REQ-008 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-009 The block SHALL have port pc, input, ADDR_W bits: instruction address.
REQ-010 The block SHALL have port instrmem_rd, input, 1 bit: instruction read request, level.
REQ-011 The block SHALL have port Instr_dout, output, DATA_W bits: instruction word.
REQ-012 The block SHALL have port complete_instr, output, 1 bit: instruction access done, one-cycle pulse.
REQ-013 The block SHALL have port data_req, input, 1 bit: data access request, level.
REQ-014 The block SHALL have port Data_addr, input, ADDR_W bits: data address.
REQ-015 The block SHALL have port Data_rd, input, 1 bit: 1 = read, 0 = write.
REQ-016 The block SHALL have port Data_din, input, DATA_W bits: write data.
REQ-017 The block SHALL have port Data_dout, output, DATA_W bits: read data.
REQ-018 The block SHALL have port complete_data, output, 1 bit: data access done, one-cycle pulse.

Function
REQ-019 The block SHALL run one independent FSM per port (IPORT, DPORT) with states IDLE, WAIT, DONE.
REQ-020 In IDLE, a sampled request SHALL capture address (and Data_rd/Data_din for DPORT), load wait counter = LAT (+ LFSR[1:0] if RAND_STALL), and go to WAIT.
REQ-021 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to DONE.
REQ-022 In DONE, the FSM SHALL assert complete_* for exactly one cycle with valid data and return to IDLE; total latency from request sample to complete is LAT+extra+1 cycles.
REQ-023 A request held high after DONE SHALL start a new access the following cycle (back-to-back throughput 1 access per LAT+extra+2 cycles).
REQ-024 Request deasserted during WAIT SHALL abort: return to IDLE, no complete pulse, no array write.
REQ-025 DPORT writes SHALL update the array on the DONE cycle only; Data_dout is unchanged by a write.
REQ-026 Instr_dout and Data_dout SHALL hold their last completed read value between accesses.
REQ-027 Addresses SHALL index the array modulo 2^DEPTH_LOG2 (upper bits ignored, silent wrap).
REQ-028 Simultaneous IPORT read and DPORT write DONE on the same index SHALL return the old word on Instr_dout (read-before-write); DPORT read and IPORT read on any index SHALL both succeed the same cycle.
REQ-029 The LFSR SHALL be 16-bit Fibonacci (taps 16,14,13,11), advancing once per cycle; IPORT uses bits [1:0], DPORT bits [3:2].

Reset
REQ-030 On reset low, both FSMs SHALL enter IDLE, counters 0, complete_instr/complete_data 0, Instr_dout/Data_dout 0, LFSR = LFSR_SEED, asynchronously.
REQ-031 Reset mid-access SHALL discard the access with no complete pulse and no write; array contents SHALL NOT be reset.

Structure
REQ-032 A shared package lc3_mem_pkg SHALL hold the port-state enum (IDLE/WAIT/DONE) and the LFSR tap constant.
REQ-033 The per-port FSM+counter SHALL be one sub-module, lc3_mem_port, instantiated twice.

Verification
REQ-034 I_LAT=0, array[0x3000&mask]=16'h1234, instrmem_rd=1 pc=16'h3000 -> complete_instr at cycle+1, Instr_dout=16'h1234.
REQ-035 D_LAT=3, write 16'hBEEF to 16'h0040 then read 16'h0040 -> each complete_data 4 cycles after request; read returns 16'hBEEF.
REQ-036 D_LAT=2, data_req dropped after 1 cycle during write of 16'h5555 -> no complete_data; later read returns prior value.
REQ-037 Same-cycle DPORT write 16'hAAAA and IPORT read to index 5 (old 16'h0005) -> Instr_dout=16'h0005; next read 16'hAAAA.
REQ-038 DEPTH_LOG2=10, write 16'h7777 at 16'h0401, read 16'h0001 -> 16'h7777.
REQ-039 RAND_STALL=1, reset low mid-WAIT -> outputs 0 immediately, no pulse; 1000 random accesses all complete within LAT+4 cycles.
